fifo_sync_hs: RTL and testbench

//  Synchronous FIFO with valid/ready handshakes on both sides, for use between pipeline stages.

---
 rtl/fifo_sync_hs.sv | 121 ++++++++++++
 tb/tb_fifo_sync_hs.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_hs.sv
// Synchronous valid/ready FIFO for any depth >= 1, with an occupancy count,
// programmable almost-full/almost-empty flags and a synchronous flush.
module fifo_sync_hs #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned AFULL_THRESH  = 3,
    parameter int unsigned AEMPTY_THRESH = 1,
    localparam int unsigned AW = (FIFO_DEPTH == 1) ? 1 : $clog2(FIFO_DEPTH),
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CW-1:0]         count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);

    if (FIFO_DEPTH < 1) begin : g_err_depth
        $error("fifo_sync_hs: FIFO_DEPTH must be >= 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_err_afull
        $error("fifo_sync_hs: AFULL_THRESH must be in 1..FIFO_DEPTH");
    end
    if (AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_err_aempty
        $error("fifo_sync_hs: AEMPTY_THRESH must be in 0..FIFO_DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push, pop, wr_en;
    logic                  full, empty;
    logic [DATA_WIDTH-1:0] head_data;

    // All status is taken from the count register, never from a pointer compare.
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    assign push  = in_valid_i & ~full;
    assign pop   = out_ready_i & ~empty;
    assign wr_en = push & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Decoded write/read keeps entry selection legal for non-power-of-2 depths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_ptr_q == AW'(i)) begin
                    mem_q[i] <= in_data_i;
                end
            end
        end
    end

    always_comb begin
        head_data = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (rd_ptr_q == AW'(i)) begin
                head_data = mem_q[i];
            end
        end
    end

    assign in_ready_o     = ~full;
    assign out_valid_o    = ~empty;
    assign out_data_o     = empty ? '0 : head_data;
    assign count_o        = count_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= CW'(AFULL_THRESH));
    assign almost_empty_o = (count_q <= CW'(AEMPTY_THRESH));

endmodule

// File: tb/tb_fifo_sync_hs.sv
// Scoreboard bench for fifo_sync_hs: a depth-5 and a depth-1 instance, each
// checked every cycle against a queue-based occupancy/data model.
module tb_fifo_sync_hs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Depth-5 instance
    logic       a_flush, a_iv, a_or;
    logic [7:0] a_id, a_od;
    logic       a_ir, a_ov, a_full, a_empty, a_af, a_ae;
    logic [2:0] a_cnt;

    // Depth-1 instance
    logic       b_flush, b_iv, b_or;
    logic [7:0] b_id, b_od;
    logic       b_ir, b_ov, b_full, b_empty, b_af, b_ae;
    logic [0:0] b_cnt;

    int total = 0;
    int bad   = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    fifo_sync_hs #(
        .DATA_WIDTH(8), .FIFO_DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .flush_i(a_flush),
        .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id),
        .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od),
        .count_o(a_cnt), .full_o(a_full), .empty_o(a_empty),
        .almost_full_o(a_af), .almost_empty_o(a_ae)
    );

    fifo_sync_hs #(
        .DATA_WIDTH(8), .FIFO_DEPTH(1), .AFULL_THRESH(1), .AEMPTY_THRESH(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .flush_i(b_flush),
        .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id),
        .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od),
        .count_o(b_cnt), .full_o(b_full), .empty_o(b_empty),
        .almost_full_o(b_af), .almost_empty_o(b_ae)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the depth-5 instance; the model is just an ordered queue.
    always @(negedge clk) begin : mon_a
        int   n;
        logic can_push;
        n = qa.size();
        chk("a_count", int'(a_cnt), n);
        chk("a_full", int'(a_full), int'(n == 5));
        chk("a_empty", int'(a_empty), int'(n == 0));
        chk("a_afull", int'(a_af), int'(n >= 4));
        chk("a_aempty", int'(a_ae), int'(n <= 1));
        chk("a_in_ready", int'(a_ir), int'(n < 5));
        chk("a_out_valid", int'(a_ov), int'(n > 0));
        chk("a_data", int'(a_od), int'((n > 0) ? qa[0] : 8'h00));
        if (!rst) begin
            if (a_flush) begin
                qa.delete();
            end else begin
                can_push = a_iv && (n < 5);
                if (a_or && n > 0) void'(qa.pop_front());
                if (can_push) qa.push_back(a_id);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        int   n;
        logic can_push;
        n = qb.size();
        chk("b_count", int'(b_cnt), n);
        chk("b_full", int'(b_full), int'(n == 1));
        chk("b_empty", int'(b_empty), int'(n == 0));
        chk("b_afull", int'(b_af), int'(n >= 1));
        chk("b_aempty", int'(b_ae), int'(n <= 0));
        chk("b_in_ready", int'(b_ir), int'(n < 1));
        chk("b_out_valid", int'(b_ov), int'(n > 0));
        chk("b_data", int'(b_od), int'((n > 0) ? qb[0] : 8'h00));
        if (!rst) begin
            if (b_flush) begin
                qb.delete();
            end else begin
                can_push = b_iv && (n < 1);
                if (b_or && n > 0) void'(qb.pop_front());
                if (can_push) qb.push_back(b_id);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_flush = 0; a_iv = 0; a_or = 0; a_id = 0;
        b_flush = 0; b_iv = 0; b_or = 0; b_id = 0;
        step();
        step();
        rst = 0;

        // Fill to full, hold a 6th word off, then drain
        for (int i = 0; i < 5; i++) begin
            a_iv = 1; a_id = 8'hA0 + 8'(i); step();
        end
        a_id = 8'hA5;
        for (int i = 0; i < 3; i++) step();
        a_iv = 0; a_or = 1;
        for (int i = 0; i < 5; i++) step();
        a_or = 0;

        // Full with simultaneous pop
        a_iv = 1;
        for (int i = 0; i < 5; i++) begin
            a_id = 8'h10 + 8'(i); step();
        end
        a_or = 1;
        a_id = 8'h20; step();
        a_id = 8'h21; step();

        // Down to 2 resident entries, then streaming across the pointer wrap
        a_iv = 0;
        step(); step();
        a_iv = 1;
        for (int i = 0; i < 23; i++) begin
            a_id = 8'h30 + 8'(i); step();
        end
        a_iv = 0;
        for (int i = 0; i < 3; i++) step();
        a_or = 0;

        // Flush beats a same-cycle push
        a_iv = 1;
        for (int i = 0; i < 3; i++) begin
            a_id = 8'h40 + 8'(i); step();
        end
        a_flush = 1; a_id = 8'h55; step();
        a_flush = 0; a_id = 8'h66; step();
        a_iv = 0; a_or = 1; step();
        a_or = 0;

        // Async reset mid-cycle with 3 entries stored
        a_iv = 1;
        for (int i = 0; i < 3; i++) begin
            a_id = 8'h70 + 8'(i); step();
        end
        a_iv = 0;
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("t1_count", int'(a_cnt), 0);
        chk("t1_empty", int'(a_empty), 1);
        chk("t1_full", int'(a_full), 0);
        chk("t1_out_valid", int'(a_ov), 0);
        chk("t1_in_ready", int'(a_ir), 1);
        chk("t1_data", int'(a_od), 0);
        chk("t1_afull", int'(a_af), 0);
        chk("t1_aempty", int'(a_ae), 1);
        qa.delete();
        qb.delete();
        step();
        rst = 0;

        // Depth-1 alternating push/pop
        for (int i = 1; i <= 4; i++) begin
            b_iv = 1; b_or = 0; b_id = 8'(i); step();
            b_iv = 0; b_or = 1; step();
        end
        b_or = 0;

        // Randomized traffic: fill-biased, then drain-biased
        for (int i = 0; i < 800; i++) begin
            a_flush = ($urandom_range(0, 29) == 0);
            b_flush = ($urandom_range(0, 29) == 0);
            a_id = 8'($urandom);
            b_id = 8'($urandom);
            if (i < 400) begin
                a_iv = ($urandom_range(0, 3) != 0);
                a_or = ($urandom_range(0, 3) == 0);
            end else begin
                a_iv = ($urandom_range(0, 3) == 0);
                a_or = ($urandom_range(0, 3) != 0);
            end
            b_iv = ($urandom_range(0, 1) == 0);
            b_or = ($urandom_range(0, 1) == 0);
            step();
        end

        a_flush = 0; b_flush = 0; a_iv = 0; b_iv = 0; a_or = 1; b_or = 1;
        for (int i = 0; i < 6; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
